// File: rtl/mips_exec_sequencer.sv
// Multicycle MIPS issue/control sequencer: fetch, register read, ALU issue,
// then writeback, branch or jump. Outputs are decodes of registered state.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN;
// without it instr_count is tied to zero and no counter flops exist.
module mips_exec_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [4:0]  rf_raddr1,
   output logic [4:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   output logic [5:0]  alu_opcode,
   output logic [5:0]  alu_func,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] pc,
   output logic        halt,
   output logic [31:0] instr_count
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned RAW  = 5;
   localparam int unsigned OPW  = 6;

   localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPW-1:0] OP_J     = 6'h02;
   localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPW-1:0] OP_ADDI  = 6'h08;

   localparam logic [OPW-1:0] FN_ADD = 6'h20;
   localparam logic [OPW-1:0] FN_SUB = 6'h22;
   localparam logic [OPW-1:0] FN_AND = 6'h24;
   localparam logic [OPW-1:0] FN_OR  = 6'h25;
   localparam logic [OPW-1:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_WRITEBACK = 3'd3,
      S_HALT      = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   ir_q, ir_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic              fetch_en_q;

   logic [OPW-1:0]    opcode_c;
   logic [OPW-1:0]    func_c;
   logic [XLEN-1:0]   imm_sext_c;
   logic [XLEN-1:0]   pc_plus4_c;
   logic [XLEN-1:0]   br_target_c;
   logic [XLEN-1:0]   j_target_c;
   logic              is_halt_word_c;
   logic              is_rtype_c;
   logic              is_addi_c;
   logic              is_beq_c;
   logic              is_j_c;
   logic [RAW-1:0]    waddr_c;

   // Instruction field decode and pc arithmetic (all modulo 2^32).
   always_comb begin
      opcode_c       = ir_q[31:26];
      func_c         = ir_q[5:0];
      imm_sext_c     = {{16{ir_q[15]}}, ir_q[15:0]};
      pc_plus4_c     = pc_q + XLEN'(4);
      br_target_c    = pc_plus4_c + {imm_sext_c[XLEN-3:0], 2'b00};
      j_target_c     = {pc_plus4_c[31:28], ir_q[25:0], 2'b00};
      is_halt_word_c = (ir_q == HALT_WORD);
      is_rtype_c     = (opcode_c == OP_RTYPE) &&
                       (func_c inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
      is_addi_c      = (opcode_c == OP_ADDI);
      is_beq_c       = (opcode_c == OP_BEQ);
      is_j_c         = (opcode_c == OP_J);
      waddr_c        = (opcode_c == OP_RTYPE) ? ir_q[15:11] : ir_q[20:16];
   end

   // Next-state and datapath-register update.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      case (state_q)
         S_FETCH: begin
            if (fetch_en_q && imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d = rf_rdata1;
            b_d = is_addi_c ? imm_sext_c : rf_rdata2;
            if (is_halt_word_c) begin
               state_d = S_HALT;
            end else if (is_j_c) begin
               pc_d    = j_target_c;
               state_d = S_FETCH;
            end else if (is_rtype_c || is_addi_c || is_beq_c) begin
               state_d = S_EXECUTE;
            end else begin
               state_d = S_HALT;
            end
         end
         S_EXECUTE: begin
            res_d = alu_result;
            if (is_beq_c) begin
               pc_d    = alu_zero ? br_target_c : pc_plus4_c;
               state_d = S_FETCH;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_WRITEBACK: begin
            pc_d    = pc_plus4_c;
            state_d = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

   // Fetch is held off until the first clock after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_en_q <= 1'b0;
      end else begin
         fetch_en_q <= 1'b1;
      end
   end

   // Interface decodes of the registered state.
   always_comb begin
      imem_req   = fetch_en_q && (state_q == S_FETCH);
      imem_addr  = pc_q;
      rf_raddr1  = ir_q[25:21];
      rf_raddr2  = ir_q[20:16];
      alu_opcode = opcode_c;
      alu_func   = func_c;
      alu_a      = a_q;
      alu_b      = b_q;
      rf_waddr   = waddr_c;
      rf_wdata   = res_q;
      rf_we      = (state_q == S_WRITEBACK) && (waddr_c != RAW'(0));
      pc         = pc_q;
      halt       = (state_q == S_HALT);
   end

`ifdef SEQ_PERF_CNT_EN
   logic [XLEN-1:0] cnt_q, cnt_d;
   logic            retire_c;

   // Retirement points: writeback exit, beq execute exit, j decode exit.
   always_comb begin
      retire_c = 1'b0;
      case (state_q)
         S_WRITEBACK: retire_c = 1'b1;
         S_EXECUTE:   retire_c = is_beq_c;
         S_DECODE:    retire_c = is_j_c && !is_halt_word_c;
         default:     retire_c = 1'b0;
      endcase
      cnt_d = cnt_q + XLEN'(retire_c);
   end

   // Retired instruction counter, wraps at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign instr_count = cnt_q;
`else
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mips_exec_sequencer.sv
// Self-checking bench for mips_exec_sequencer: directed cases then random
// instruction stream, checked against an instruction-level reference model.
module tb_mips_exec_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic [5:0]  alu_opcode;
   logic [5:0]  alu_func;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pc;
   logic        halt;
   logic [31:0] instr_count;

   // Architectural reference state; m_rf also serves the DUT's read ports.
   logic [31:0] m_rf [32];
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic        zovr_en;
   logic        zovr_val;

   int total;
   int bad;

   mips_exec_sequencer #(
      .RESET_PC  (RST_PC),
      .HALT_WORD (HALT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .rf_raddr1   (rf_raddr1),
      .rf_raddr2   (rf_raddr2),
      .rf_rdata1   (rf_rdata1),
      .rf_rdata2   (rf_rdata2),
      .alu_opcode  (alu_opcode),
      .alu_func    (alu_func),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .pc          (pc),
      .halt        (halt),
      .instr_count (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic meaning of each supported operation.
   function automatic logic [31:0] op_value(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
      case (op)
         6'h08: return a + b;
         6'h04: return a - b;
         6'h00: begin
            case (fn)
               6'h20: return a + b;
               6'h22: return a - b;
               6'h24: return a & b;
               6'h25: return a | b;
               6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: return 32'd0;
            endcase
         end
         default: return 32'd0;
      endcase
   endfunction

   assign rf_rdata1  = m_rf[rf_raddr1];
   assign rf_rdata2  = m_rf[rf_raddr2];
   assign alu_result = op_value(alu_opcode, alu_func, alu_a, alu_b);
   assign alu_zero   = zovr_en ? zovr_val : (alu_result == 32'd0);

   function automatic logic [31:0] exp_count();
`ifdef SEQ_PERF_CNT_EN
      return m_cnt;
`else
      return 32'd0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Serve one instruction fetch and follow it to retirement or halt.
   task automatic run_instr(input logic [31:0] ins, input int wt);
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs, rt, rd, dst, wa;
      logic [31:0] rs_v, rt_v, sx, exp_b, exp_res, npc, wd;
      bit          legal, wr_exp, taken;
      int          lat, cyc, wr_n;
      wait_req();
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_addr", imem_addr, m_pc);
      for (int i = 0; i < wt; i++) begin
         imem_ack = 1'b0;
         @(negedge clk);
         check("req_held", 32'(imem_req), 32'd1);
         check("addr_held", imem_addr, m_pc);
      end
      imem_ack   = 1'b1;
      imem_rdata = ins;
      @(negedge clk);
      imem_ack   = 1'b0;

      op = ins[31:26]; fn = ins[5:0];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      rs_v = m_rf[rs]; rt_v = m_rf[rt];
      sx = {{16{ins[15]}}, ins[15:0]};
      legal = 1'b1; wr_exp = 1'b0; lat = 4; dst = 5'd0;
      npc = m_pc + 32'd4; exp_b = rt_v; exp_res = 32'd0;
      if (ins == HALT_W) begin
         legal = 1'b0;
      end else begin
         case (op)
            6'h00: begin
               if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
                  exp_res = op_value(op, fn, rs_v, rt_v);
                  dst = rd; wr_exp = (rd != 5'd0);
               end else begin
                  legal = 1'b0;
               end
            end
            6'h08: begin
               exp_b = sx; exp_res = rs_v + sx;
               dst = rt; wr_exp = (rt != 5'd0);
            end
            6'h04: begin
               lat = 3;
               taken = zovr_en ? zovr_val : (rs_v == rt_v);
               if (taken) npc = m_pc + 32'd4 + (sx << 2);
            end
            6'h02: begin
               lat = 2;
               npc = {npc[31:28], ins[25:0], 2'b00};
            end
            default: legal = 1'b0;
         endcase
      end

      cyc = 1; wr_n = 0; wa = 5'd0; wd = 32'd0;
      while (!imem_req && !halt && cyc < 12) begin
         cyc++;
         if (cyc == 3 && legal && op != 6'h02) begin
            check("alu_opcode", 32'(alu_opcode), 32'(op));
            check("alu_func", 32'(alu_func), 32'(fn));
            check("alu_a", alu_a, rs_v);
            check("alu_b", alu_b, exp_b);
         end
         if (rf_we) begin
            wr_n++; wa = rf_waddr; wd = rf_wdata;
         end
         imem_ack   = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
         @(negedge clk);
      end
      imem_ack = 1'b0;

      if (legal) begin
         check("latency", 32'(cyc), 32'(lat));
         check("no_halt", 32'(halt), 32'd0);
         check("next_pc", pc, npc);
         check("write_cnt", 32'(wr_n), 32'(wr_exp));
         if (wr_exp) begin
            check("wr_addr", 32'(wa), 32'(dst));
            check("wr_data", wd, exp_res);
            m_rf[dst] = exp_res;
         end
         m_pc  = npc;
         m_cnt = m_cnt + 32'd1;
      end else begin
         check("halt_set", 32'(halt), 32'd1);
         check("halt_req", 32'(imem_req), 32'd0);
         check("halt_pc", pc, m_pc);
         check("halt_nowr", 32'(wr_n), 32'd0);
      end
   endtask

   // Stay halted for a few cycles while ack is waved at the DUT.
   task automatic check_halted();
      for (int i = 0; i < 5; i++) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'h0022_1820;
         @(negedge clk);
         check("stay_halt", 32'(halt), 32'd1);
         check("stay_noreq", 32'(imem_req | rf_we), 32'd0);
      end
      imem_ack = 1'b0;
      check("halt_count", instr_count, exp_count());
   endtask

   initial begin
      logic [31:0] ins;
      logic [15:0] imm;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  fn;
      int          d, sel;
      logic [5:0]  fn_tab [5];
      fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
      fn_tab[3] = 6'h25; fn_tab[4] = 6'h2A;
      total = 0; bad = 0;
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
      zovr_en = 1'b0; zovr_val = 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] = $urandom;
      m_rf[0] = 32'd0; m_rf[1] = 32'd5; m_rf[2] = 32'd7;
      m_pc = RST_PC; m_cnt = 32'd0;

      // Reset values and release behaviour.
      repeat (2) @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_pc", pc, RST_PC);
      check("rst_halt", 32'(halt), 32'd0);
      check("rst_we", 32'(rf_we), 32'd0);
      check("rst_count", instr_count, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rel_req0", 32'(imem_req), 32'd0);
      @(negedge clk);
      check("rel_req1", 32'(imem_req), 32'd1);
      check("rel_addr", imem_addr, RST_PC);
      rst_n = 1'b0;
      #1;
      check("rst_fetch_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed instructions.
      run_instr(32'h0022_1820, 0);
      run_instr(32'h2020_FFFF, 0);
      run_instr(32'h0800_0080, 0);
      run_instr(32'h1021_0003, 0);
      check("beq_taken_pc", pc, 32'h0000_0210);
      run_instr(32'h0800_0080, 0);
      zovr_en = 1'b1; zovr_val = 1'b0;
      run_instr(32'h1021_0003, 0);
      zovr_en = 1'b0;
      check("beq_fall_pc", pc, 32'h0000_0204);

      // Walk pc backwards through zero to 0xF000_0000 with beq $0,$0.
      while (m_pc != 32'hF000_0000 && bad == 0) begin
         d = int'(32'hF000_0000 - (m_pc + 32'd4));
         imm = (d >= -131072) ? 16'(d >>> 2) : 16'h8000;
         run_instr({16'h1000, imm}, 0);
      end
      run_instr(32'h0800_0040, 3);
      check("j_region_pc", pc, 32'hF000_0100);

      // Random instruction stream.
      for (int k = 0; k < 400; k++) begin
         sel = $urandom_range(0, 9);
         rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         rd = 5'($urandom_range(0, 7));
         fn = fn_tab[$urandom_range(0, 4)];
         imm = 16'($urandom);
         if (sel <= 4)      ins = {6'h00, rs, rt, rd, 5'($urandom), fn};
         else if (sel <= 6) ins = {6'h08, rs, rt, imm};
         else if (sel <= 8) ins = {6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, imm};
         else               ins = {6'h02, 26'($urandom)};
         run_instr(ins, $urandom_range(0, 2));
      end
      check("perf_count", instr_count, exp_count());

      // Illegal opcode halts permanently.
      run_instr({6'h23, 26'h0}, 0);
      check_halted();

      // HALT_WORD after a fresh reset.
      rst_n = 1'b0;
      @(negedge clk);
      check("rst2_halt", 32'(halt), 32'd0);
      check("rst2_count", instr_count, 32'd0);
      rst_n = 1'b1;
      m_pc = RST_PC; m_cnt = 32'd0;
      run_instr(HALT_W, 0);
      check_halted();

      // Reset during writeback abandons the write.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_req();
      imem_ack = 1'b1; imem_rdata = 32'h0022_1820;
      @(negedge clk);
      imem_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("wb_we", 32'(rf_we), 32'd1);
      rst_n = 1'b0;
      #1;
      check("wb_rst_we", 32'(rf_we), 32'd0);
      check("wb_rst_pc", pc, RST_PC);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("wb_rst_req", 32'(imem_req), 32'd1);
      check("wb_rst_count", instr_count, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
